// File: rtl/adder_pkg.sv
// Shared constants and elaboration helpers for the pipelined add/subtract unit.
package adder_pkg;

    localparam int WIDTH_DEF  = 32;
    localparam int STAGES_DEF = 4;

    function automatic int chunk_width(input int width, input int stages);
        return width / stages;
    endfunction

    function automatic bit width_divisible(input int width, input int stages);
        return (stages > 0) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/adder_stage.sv
// One carry-chunk of the adder: combinational CHUNK-bit add with carry in/out.
module adder_stage #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] full;

    assign full  = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    assign sum   = full[CHUNK-1:0];
    assign cout  = full[CHUNK];
    // The MSB sum bit is a^b^carry_in, so the carry into it falls out for free.
    assign c_msb = a[CHUNK-1] ^ b[CHUNK-1] ^ full[CHUNK-1];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit: one CHUNK-bit carry chunk per stage, valid/ready flow control.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int STAGES = STAGES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    input  logic             sub_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out,
    output logic             ovf_out
);

    localparam int CHUNK = chunk_width(WIDTH, STAGES);
    localparam int LAST  = STAGES - 1;
    localparam logic [WIDTH-1:0] CHUNK_MASK = (WIDTH'(1) << CHUNK) - WIDTH'(1);

    if (!width_divisible(WIDTH, STAGES)) begin : g_width_check
        $error("pipelined_adder: WIDTH must be a multiple of STAGES");
    end

    logic [STAGES:0]                 ready;
    logic [STAGES-1:0]               vld_pipe, cy_q;
    logic [STAGES-1:0][WIDTH-1:0]    sum_q, a_q, b_q;
    logic                            ovf_q;

    logic [STAGES-1:0]               v_src, c_src, cout_w, cmsb_w;
    logic [STAGES-1:0][WIDTH-1:0]    a_src, b_src, s_src, sum_d;
    logic [STAGES-1:0][CHUNK-1:0]    csum;
    logic [WIDTH-1:0]                b_eff;

    assign b_eff         = b_in ^ {WIDTH{sub_in}};
    assign ready[STAGES] = out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign v_src[k] = in_valid;
            assign a_src[k] = a_in;
            assign b_src[k] = b_eff;
            assign c_src[k] = cin_in ^ sub_in;
            assign s_src[k] = '0;
        end else begin : g_body
            assign v_src[k] = vld_pipe[k-1];
            assign a_src[k] = a_q[k-1];
            assign b_src[k] = b_q[k-1];
            assign c_src[k] = cy_q[k-1];
            assign s_src[k] = sum_q[k-1];
        end

        adder_stage #(.CHUNK(CHUNK)) u_stage (
            .a     (a_src[k][k*CHUNK +: CHUNK]),
            .b     (b_src[k][k*CHUNK +: CHUNK]),
            .cin   (c_src[k]),
            .sum   (csum[k]),
            .cout  (cout_w[k]),
            .c_msb (cmsb_w[k])
        );

        // Lower chunks pass through already computed; this stage fills in chunk k.
        assign sum_d[k] = (s_src[k] & ~(CHUNK_MASK << (k*CHUNK)))
                        | (WIDTH'(csum[k]) << (k*CHUNK));
        assign ready[k] = ~vld_pipe[k] | ready[k+1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            cy_q     <= '0;
            sum_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            ovf_q    <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (ready[k]) begin
                    vld_pipe[k] <= v_src[k];
                    sum_q[k]    <= sum_d[k];
                    cy_q[k]     <= cout_w[k];
                    a_q[k]      <= a_src[k];
                    b_q[k]      <= b_src[k];
                end
            end
            if (ready[LAST])
                ovf_q <= cmsb_w[LAST] ^ cout_w[LAST];
        end
    end

    assign in_ready  = ready[0] & ~rst;
    assign out_valid = vld_pipe[LAST];
    assign sum_out   = sum_q[LAST];
    assign cout_out  = cy_q[LAST];
    assign ovf_out   = ovf_q;

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined add/subtract unit with carry-in, carry-out and signed overflow, split into STAGES carry-chunk pipeline stages with valid/ready flow control. It replaces the single-bit registered full adder wherever the datapath needs wide operands at full clock rate. It sits between an operand producer and a result consumer. Both sides use valid/ready handshakes.

## Interface
- WIDTH, 32: operand/result width in bits; WIDTH % STAGES must be 0.
- STAGES, 4: number of pipeline stages; also the chunk count. CHUNK = WIDTH/STAGES bits per stage.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts the beat this cycle.
- a_in  in  WIDTH  operand A.
- b_in  in  WIDTH  operand B.
- cin_in  in  1  carry-in.
- sub_in  in  1  0 = A+B+cin; 1 = A-B (A + ~B + ~cin... see Operation).
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts the result.
- sum_out  out  WIDTH  result.
- cout_out  out  1  carry out of MSB (no-borrow when subtracting).
- ovf_out  out  1  two's-complement overflow.

## Operation
- Effective operands:
  - b_eff = b_in ^ {WIDTH{sub_in}}.
  - c0 = cin_in ^ sub_in.
  - So sub=1, cin=0 gives A-B; sub=1, cin=1 gives A-B-1.
- Accept on a rising edge with in_valid & in_ready. Output transfer on out_valid & out_ready.
- Stage k (0..STAGES-1) holds:
  - valid_k;
  - result bits [(k+1)*CHUNK-1:0], already computed;
  - the carry out of chunk k;
  - the remaining upper operand bits of a and b_eff, skewed forward;
  - sign bits a_msb and b_eff_msb.
- Stage 0 computes chunk 0 from the ports with c0. Stage k>0 computes chunk k from the stage k-1 register and its carry.
- The last stage feeds sum_out, cout_out and out_valid directly:
  - cout_out = carry out of bit WIDTH-1.
  - ovf_out = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
- Flow control:
  - ready_STAGES = out_ready.
  - ready_k = ~valid_k | ready_{k+1}.
  - in_ready = ready_0.
  - Stage k loads when ready_k. valid_k takes the upstream valid, so bubbles collapse.
  - The combinational ready path from out_ready to in_ready is accepted.
- A stalled stage holds all of its bits unchanged. sum_out, cout_out and ovf_out stay stable while out_valid & ~out_ready.
- Results leave in acceptance order. No reordering, no drop, no duplication.
- STAGES=1 degenerates to a registered adder with one-cycle latency.

## Timing
- Reset (asynchronous assert, synchronous-safe release):
  - all valid_k = 0, all data registers = 0;
  - out_valid = 0, sum_out = 0, cout_out = 0, ovf_out = 0;
  - in_ready = 0 while rst is high, 1 on the first cycle after release.
- Latency: a beat accepted at edge N shows out_valid = 1 in the cycle after edge N+STAGES-1, i.e. STAGES cycles, provided there are no stalls.
- Throughput: one beat per cycle while out_ready = 1.
- Full pipeline: all valid_k = 1 and out_ready = 0 gives in_ready = 0. At most STAGES beats are in flight.
- Simultaneous events on a full pipeline: out_ready rising with in_valid high drains one beat and accepts one beat on the same edge.
- Reset mid-operation: all in-flight beats are discarded immediately (asynchronously). No out_valid follows the reset.
- Wrap-around: sum_out is taken modulo 2^WIDTH. Any overflow is reported only through cout_out and ovf_out.

## Structure
- Package adder_pkg holds:
  - the default WIDTH and STAGES constants;
  - a CHUNK computation function;
  - an elaboration check that WIDTH % STAGES == 0.
- One sub-module, adder_stage, parametrised by CHUNK:
  - a combinational chunk add (a, b, cin -> sum, cout, carry into its MSB);
  - instantiated STAGES times via generate.
- Pipeline registers and the ready chain live in pipelined_adder.

## Test plan
All scenarios use WIDTH=8, STAGES=4.
- Reset: assert rst mid-stream -> out_valid, sum_out, cout_out and ovf_out are 0 immediately; in_ready = 1 on the first cycle after release.
- Add: a=0xFF, b=0x01, cin=0, sub=0 -> 4 cycles later sum=0x00, cout=1, ovf=0.
- Add: a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1.
- Subtract: a=0x80, b=0x01, sub=1, cin=0 -> sum=0x7F, cout=1, ovf=1.
- Subtract: a=0x03, b=0x05, sub=1 -> sum=0xFE, cout=0, ovf=0.
- Stream: 16 back-to-back random beats with out_ready=1 -> 16 results, one per cycle, in order, all matching the model.
- Backpressure: stream with out_ready low for 6 cycles -> exactly 4 beats accepted, in_ready=0, outputs held stable. On release the stream resumes with no loss or duplication, and a drain and an accept occur on the same edge.
